mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and RAM signal bundle for the memory arbiter
interface mem_arbiter_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10
);
  // Fetch port (read-only)
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [WIDTH-1:0]      i_rdata;
  // Data port (read/write)
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [WIDTH-1:0]      d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [WIDTH-1:0]      d_rdata;
  // RAM side
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_wren;
  logic [WIDTH-1:0]      ram_wdata;
  logic [WIDTH-1:0]      ram_rdata;
  logic                  busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           ram_addr, ram_wren, ram_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           ram_addr, ram_wren, ram_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/data arbiter for a single-port synchronous RAM
module mem_arbiter #(
  parameter int WIDTH        = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  localparam int CW = $clog2(READ_LATENCY + 1);

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("mem_arbiter: READ_LATENCY must be in 1..4");
    end
  endgenerate

  typedef enum logic { IDLE = 1'b0, WAIT = 1'b1 } state_t;
  typedef enum logic { FETCH = 1'b0, DATA = 1'b1 } owner_t;

  state_t                state_q, state_d;
  owner_t                owner_q, owner_d;
  owner_t                last_grant_q, last_grant_d;
  logic [CW-1:0]         lat_cnt_q, lat_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic                  i_gnt_c, d_gnt_c, i_rvalid_c, d_rvalid_c;
  logic [WIDTH-1:0]      i_rdata_c, d_rdata_c, ram_wdata_c;
  logic [ADDR_WIDTH-1:0] ram_addr_c;
  logic                  ram_wren_c, busy_c;
  logic                  pick_i, pick_d;

  // State registers; reset leaves DATA as last winner so the first tie goes to fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= FETCH;
      last_grant_q <= DATA;
      lat_cnt_q    <= '0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      lat_cnt_q    <= lat_cnt_d;
      addr_q       <= addr_d;
    end
  end

  // Arbitration, RAM drive and read-return steering
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    lat_cnt_d    = lat_cnt_q;
    addr_d       = addr_q;
    i_gnt_c      = 1'b0;
    d_gnt_c      = 1'b0;
    i_rvalid_c   = 1'b0;
    d_rvalid_c   = 1'b0;
    i_rdata_c    = '0;
    d_rdata_c    = '0;
    ram_addr_c   = '0;
    ram_wren_c   = 1'b0;
    ram_wdata_c  = '0;
    busy_c       = 1'b0;
    pick_i       = bus.i_req && (!bus.d_req || last_grant_q == DATA);
    pick_d       = bus.d_req && !pick_i;

    case (state_q)
      IDLE: begin
        if (pick_i) begin
          i_gnt_c      = 1'b1;
          ram_addr_c   = bus.i_addr;
          last_grant_d = FETCH;
          owner_d      = FETCH;
          addr_d       = bus.i_addr;
          lat_cnt_d    = CW'(1);
          state_d      = WAIT;
        end else if (pick_d) begin
          d_gnt_c      = 1'b1;
          ram_addr_c   = bus.d_addr;
          last_grant_d = DATA;
          if (bus.d_we) begin
            // Writes complete in the grant cycle; no return phase
            ram_wren_c  = 1'b1;
            ram_wdata_c = bus.d_wdata;
          end else begin
            owner_d   = DATA;
            addr_d    = bus.d_addr;
            lat_cnt_d = CW'(1);
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        busy_c     = 1'b1;
        ram_addr_c = addr_q;
        if (lat_cnt_q == CW'(READ_LATENCY)) begin
          if (owner_q == FETCH) begin
            i_rvalid_c = 1'b1;
            i_rdata_c  = bus.ram_rdata;
          end else begin
            d_rvalid_c = 1'b1;
            d_rdata_c  = bus.ram_rdata;
          end
          lat_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs forced low while reset is asserted, even with requests pending
  assign bus.i_gnt     = rst_n & i_gnt_c;
  assign bus.d_gnt     = rst_n & d_gnt_c;
  assign bus.i_rvalid  = rst_n & i_rvalid_c;
  assign bus.d_rvalid  = rst_n & d_rvalid_c;
  assign bus.i_rdata   = rst_n ? i_rdata_c : '0;
  assign bus.d_rdata   = rst_n ? d_rdata_c : '0;
  assign bus.ram_addr  = rst_n ? ram_addr_c : '0;
  assign bus.ram_wren  = rst_n & ram_wren_c;
  assign bus.ram_wdata = rst_n ? ram_wdata_c : '0;
  assign bus.busy      = rst_n & busy_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter at read latency 1 and 3
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.WIDTH(32), .ADDR_WIDTH(10)) bus1 ();
  mem_arbiter_if #(.WIDTH(32), .ADDR_WIDTH(10)) bus3 ();

  mem_arbiter #(.WIDTH(32), .ADDR_WIDTH(10), .READ_LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  mem_arbiter #(.WIDTH(32), .ADDR_WIDTH(10), .READ_LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  // Synchronous RAM models: one register stage for latency 1, three for latency 3
  logic [31:0] mem1 [1024];
  logic [31:0] mem3 [1024];
  logic [31:0] p1;
  logic [31:0] q3 [3];
  assign bus1.ram_rdata = p1;
  assign bus3.ram_rdata = q3[2];

  always @(posedge clk) begin
    if (bus1.ram_wren) mem1[bus1.ram_addr] <= bus1.ram_wdata;
    p1 <= mem1[bus1.ram_addr];
    if (bus3.ram_wren) mem3[bus3.ram_addr] <= bus3.ram_wdata;
    q3[0] <= mem3[bus3.ram_addr];
    q3[1] <= q3[0];
    q3[2] <= q3[1];
  end

  typedef struct {
    logic        ir;
    logic [9:0]  ia;
    logic        dr;
    logic        dwe;
    logic [9:0]  da;
    logic [31:0] dwd;
    logic        ig;
    logic        dg;
    logic        iv;
    logic        dv;
    logic [31:0] ird;
    logic [31:0] drd;
    logic [9:0]  ra;
    logic        rw;
    logic [31:0] rwd;
    logic        bz;
  } vec_t;

  vec_t vq[$];
  int total = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic idle_all();
    bus1.i_req = 0; bus1.i_addr = 0; bus1.d_req = 0; bus1.d_we = 0;
    bus1.d_addr = 0; bus1.d_wdata = 0;
    bus3.i_req = 0; bus3.i_addr = 0; bus3.d_req = 0; bus3.d_we = 0;
    bus3.d_addr = 0; bus3.d_wdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Advance one cycle: next negedge, then settle
  task automatic next_cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic drv3(input logic ir, input logic [9:0] ia, input logic dr, input logic [9:0] da);
    bus3.i_req = ir; bus3.i_addr = ia; bus3.d_req = dr; bus3.d_we = 0; bus3.d_addr = da;
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) begin
      mem1[k] = 32'h0;
      mem3[k] = 32'h0;
    end
    mem1[10'h004] = 32'h00500093;
    mem1[10'h020] = 32'h11112222;
    mem1[10'h030] = 32'h33334444;
    mem3[10'h004] = 32'hAAAA0004;
    mem3[10'h020] = 32'hBBBB0020;

    // Reset held with both requests high: every output must be 0
    idle_all();
    bus1.i_req = 1; bus1.d_req = 1; bus1.i_addr = 10'h004; bus1.d_addr = 10'h020;
    next_cyc();
    chk("rst.i_gnt", bus1.i_gnt, 0);
    chk("rst.d_gnt", bus1.d_gnt, 0);
    chk("rst.ram_addr", bus1.ram_addr, 0);
    chk("rst.ram_wren", bus1.ram_wren, 0);
    chk("rst.busy", bus1.busy, 0);
    chk("rst.rvalid", {bus1.i_rvalid, bus1.d_rvalid}, 0);

    // Release with no requests
    @(negedge clk);
    rst_n = 1'b1;
    idle_all();
    #2;
    chk("rel.gnt", {bus1.i_gnt, bus1.d_gnt}, 0);
    chk("rel.busy", bus1.busy, 0);
    chk("rel.ram_wren", bus1.ram_wren, 0);

    // Latency-1 vector table, one entry per cycle
    //         ir ia      dr we da      dwd            ig dg iv dv ird            drd            ra      rw rwd            bz
    vq.push_back('{0, 0,     0, 0, 0,     0,             0, 0, 0, 0, 0,             0,             0,      0, 0,             0});
    vq.push_back('{1, 'h004, 0, 0, 0,     0,             1, 0, 0, 0, 0,             0,             'h004,  0, 0,             0});
    vq.push_back('{0, 0,     0, 0, 0,     0,             0, 0, 1, 0, 'h00500093,    0,             'h004,  0, 0,             1});
    vq.push_back('{1, 'h030, 1, 0, 'h020, 0,             0, 1, 0, 0, 0,             0,             'h020,  0, 0,             0});
    vq.push_back('{1, 'h030, 0, 0, 0,     0,             0, 0, 0, 1, 0,             'h11112222,    'h020,  0, 0,             1});
    vq.push_back('{1, 'h030, 0, 0, 0,     0,             1, 0, 0, 0, 0,             0,             'h030,  0, 0,             0});
    vq.push_back('{0, 0,     0, 0, 0,     0,             0, 0, 1, 0, 'h33334444,    0,             'h030,  0, 0,             1});
    vq.push_back('{0, 0,     1, 1, 'h010, 'hDEADBEEF,    0, 1, 0, 0, 0,             0,             'h010,  1, 'hDEADBEEF,    0});
    vq.push_back('{1, 'h010, 0, 0, 0,     0,             1, 0, 0, 0, 0,             0,             'h010,  0, 0,             0});
    vq.push_back('{0, 0,     0, 0, 0,     0,             0, 0, 1, 0, 'hDEADBEEF,    0,             'h010,  0, 0,             1});
    vq.push_back('{1, 'h004, 1, 0, 'h020, 0,             0, 1, 0, 0, 0,             0,             'h020,  0, 0,             0});
    vq.push_back('{1, 'h004, 1, 0, 'h020, 0,             0, 0, 0, 1, 0,             'h11112222,    'h020,  0, 0,             1});
    vq.push_back('{1, 'h004, 1, 0, 'h020, 0,             1, 0, 0, 0, 0,             0,             'h004,  0, 0,             0});
    vq.push_back('{0, 0,     1, 0, 'h020, 0,             0, 0, 1, 0, 'h00500093,    0,             'h004,  0, 0,             1});
    vq.push_back('{0, 0,     1, 0, 'h020, 0,             0, 1, 0, 0, 0,             0,             'h020,  0, 0,             0});
    vq.push_back('{0, 0,     0, 0, 0,     0,             0, 0, 0, 1, 0,             'h11112222,    'h020,  0, 0,             1});

    for (int k = 0; k < vq.size(); k++) begin
      @(negedge clk);
      bus1.i_req = vq[k].ir; bus1.i_addr = vq[k].ia;
      bus1.d_req = vq[k].dr; bus1.d_we = vq[k].dwe;
      bus1.d_addr = vq[k].da; bus1.d_wdata = vq[k].dwd;
      #2;
      chk($sformatf("v%0d.i_gnt", k), bus1.i_gnt, vq[k].ig);
      chk($sformatf("v%0d.d_gnt", k), bus1.d_gnt, vq[k].dg);
      chk($sformatf("v%0d.i_rvalid", k), bus1.i_rvalid, vq[k].iv);
      chk($sformatf("v%0d.d_rvalid", k), bus1.d_rvalid, vq[k].dv);
      chk($sformatf("v%0d.i_rdata", k), bus1.i_rdata, vq[k].ird);
      chk($sformatf("v%0d.d_rdata", k), bus1.d_rdata, vq[k].drd);
      chk($sformatf("v%0d.ram_addr", k), bus1.ram_addr, vq[k].ra);
      chk($sformatf("v%0d.ram_wren", k), bus1.ram_wren, vq[k].rw);
      chk($sformatf("v%0d.ram_wdata", k), bus1.ram_wdata, vq[k].rwd);
      chk($sformatf("v%0d.busy", k), bus1.busy, vq[k].bz);
    end

    // Latency 3: simultaneous requests after reset, fetch wins first
    do_reset();
    @(negedge clk);
    drv3(1, 10'h004, 1, 10'h020);
    #2;
    chk("l3.tie.i_gnt", bus3.i_gnt, 1);
    chk("l3.tie.d_gnt", bus3.d_gnt, 0);
    chk("l3.tie.ram_addr", bus3.ram_addr, 10'h004);
    @(negedge clk);
    drv3(0, 0, 1, 10'h020);
    for (int c = 1; c <= 3; c++) begin
      #2;
      chk($sformatf("l3.tie.busy%0d", c), bus3.busy, 1);
      chk($sformatf("l3.tie.d_gnt%0d", c), bus3.d_gnt, 0);
      chk($sformatf("l3.tie.i_rvalid%0d", c), bus3.i_rvalid, (c == 3) ? 1 : 0);
      if (c < 3) @(negedge clk);
    end
    chk("l3.tie.i_rdata", bus3.i_rdata, 32'hAAAA0004);
    next_cyc();
    chk("l3.tie.d_gnt4", bus3.d_gnt, 1);
    chk("l3.tie.busy4", bus3.busy, 0);
    chk("l3.tie.ram_addr4", bus3.ram_addr, 10'h020);
    @(negedge clk);
    drv3(0, 0, 0, 0);
    next_cyc();
    next_cyc();
    chk("l3.tie.d_rvalid", bus3.d_rvalid, 1);
    chk("l3.tie.d_rdata", bus3.d_rdata, 32'hBBBB0020);

    // Latency 3: fetch raised during a data read is held off until IDLE
    @(negedge clk);
    drv3(0, 0, 1, 10'h020);
    #2;
    chk("l3.hold.d_gnt", bus3.d_gnt, 1);
    @(negedge clk);
    drv3(1, 10'h004, 0, 0);
    for (int c = 1; c <= 3; c++) begin
      #2;
      chk($sformatf("l3.hold.i_gnt%0d", c), bus3.i_gnt, 0);
      chk($sformatf("l3.hold.busy%0d", c), bus3.busy, 1);
      chk($sformatf("l3.hold.d_rvalid%0d", c), bus3.d_rvalid, (c == 3) ? 1 : 0);
      if (c < 3) @(negedge clk);
    end
    next_cyc();
    chk("l3.hold.i_gnt4", bus3.i_gnt, 1);
    chk("l3.hold.busy4", bus3.busy, 0);

    // Latency 3: reset in the middle of a read aborts it
    do_reset();
    @(negedge clk);
    drv3(0, 0, 1, 10'h020);
    #2;
    chk("l3.abort.d_gnt", bus3.d_gnt, 1);
    @(negedge clk);
    rst_n = 1'b0;
    drv3(0, 0, 0, 0);
    #2;
    chk("l3.abort.busy_rst", bus3.busy, 0);
    chk("l3.abort.d_rvalid_rst", bus3.d_rvalid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #2;
      chk($sformatf("l3.abort.d_rvalid%0d", c), bus3.d_rvalid, 0);
      chk($sformatf("l3.abort.busy%0d", c), bus3.busy, 0);
      @(negedge clk);
    end
    drv3(1, 10'h004, 0, 0);
    #2;
    chk("l3.abort.i_gnt", bus3.i_gnt, 1);
    chk("l3.abort.ram_addr", bus3.ram_addr, 10'h004);

    @(negedge clk);
    idle_all();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
